// File: rtl/rf_wb_arbiter.sv
// Two-port register-file writeback arbiter: round-robin grant, one registered write per cycle,
// per-requester saturating handshake counters. Register 0 is never written.
module rf_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req0_ready,
  output logic                  req1_ready,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  last_grant,
  output logic [15:0]           wr_cnt0,
  output logic [15:0]           wr_cnt1
);

  logic                  grant_ok;
  logic                  hs0;
  logic                  hs1;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant_ok   = !hold && !rst;
    req0_ready = grant_ok && req0_valid && (!req1_valid || last_grant);
    req1_ready = grant_ok && req1_valid && (!req0_valid || !last_grant);
    hs0        = req0_valid && req0_ready;
    hs1        = req1_valid && req1_ready;
    sel_addr   = hs1 ? req1_addr : req0_addr;
    sel_data   = hs1 ? req1_data : req0_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      last_grant <= 1'b1;
      wr_cnt0    <= '0;
      wr_cnt1    <= '0;
    end else begin
      RegWrite <= 1'b0;
      if (hs0 || hs1) begin
        last_grant <= hs1;
        // A register-0 handshake is consumed but leaves the write port untouched.
        if (sel_addr != '0) begin
          RegWrite <= 1'b1;
          wr_addr  <= sel_addr;
          wr_data  <= sel_data;
        end
      end
      if (hs0 && wr_cnt0 != 16'hFFFF)
        wr_cnt0 <= wr_cnt0 + 16'd1;
      if (hs1 && wr_cnt1 != 16'hFFFF)
        wr_cnt1 <= wr_cnt1 + 16'd1;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of grants, writes and counters.
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, hold;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          RegWrite;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          last_grant;
  logic [15:0]   wr_cnt0, wr_cnt1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_last = 1;
  int          m_cnt[2] = '{0, 0};
  bit          m_we = 1'b0;
  int unsigned m_addr = 0;
  int unsigned m_data = 0;
  bit          m_known = 1'b1;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .RegWrite(RegWrite), .wr_addr(wr_addr), .wr_data(wr_data),
    .last_grant(last_grant), .wr_cnt0(wr_cnt0), .wr_cnt1(wr_cnt1)
  );

  function automatic int pickGrant();
    if (rst || hold) return -1;
    if (req0_valid && req1_valid) return 1 - m_last;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkRegs();
    checkOutput("RegWrite", {63'd0, RegWrite}, {63'd0, m_we});
    checkOutput("last_grant", {63'd0, last_grant}, 64'(m_last));
    checkOutput("wr_cnt0", {48'd0, wr_cnt0}, 64'(m_cnt[0]));
    checkOutput("wr_cnt1", {48'd0, wr_cnt1}, 64'(m_cnt[1]));
    if (m_known) begin
      checkOutput("wr_addr", {59'd0, wr_addr}, 64'(m_addr));
      checkOutput("wr_data", {32'd0, wr_data}, 64'(m_data));
    end
  endtask

  // One clock cycle: drive inputs, check grants, clock it, advance the model, check registers.
  task automatic applyStimulus(input logic r, input logic h,
                               input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    int g;
    int unsigned ga, gd;
    @(negedge clk);
    rst = r; hold = h;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    g = pickGrant();
    checkOutput("req0_ready", {63'd0, req0_ready}, {63'd0, g == 0});
    checkOutput("req1_ready", {63'd0, req1_ready}, {63'd0, g == 1});
    @(posedge clk);
    if (r) begin
      m_last = 1; m_cnt[0] = 0; m_cnt[1] = 0;
      m_we = 1'b0; m_addr = 0; m_data = 0; m_known = 1'b1;
    end else if (g >= 0) begin
      ga = (g == 0) ? 32'(a0) : 32'(a1);
      gd = (g == 0) ? d0 : d1;
      m_last = g;
      if (m_cnt[g] < 65535) m_cnt[g]++;
      if (ga != 0) begin
        m_we = 1'b1; m_addr = ga; m_data = gd; m_known = 1'b1;
      end else begin
        m_we = 1'b0; m_known = 1'b0;
      end
    end else begin
      m_we = 1'b0;
    end
    #1;
    checkRegs();
  endtask

  initial begin
    // Reset with both requesters already valid
    applyStimulus(1, 0, 1, 5'd3, 32'hA, 1, 5'd4, 32'hB);
    applyStimulus(1, 0, 1, 5'd3, 32'hA, 1, 5'd4, 32'hB);
    // Tie after reset: grants 0,1,0
    repeat (3) applyStimulus(0, 0, 1, 5'd3, 32'hA, 1, 5'd4, 32'hB);
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    $display("[TB] tie scenario done");

    // Single requester
    applyStimulus(0, 0, 0, 5'd9, 32'h1, 1, 5'd7, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 5'd9, 32'h1, 0, 5'd7, 32'hDEADBEEF);

    // Hold for 3 cycles, then release and alternate
    repeat (3) applyStimulus(0, 1, 1, 5'd10, 32'h10, 1, 5'd11, 32'h11);
    repeat (2) applyStimulus(0, 0, 1, 5'd10, 32'h10, 1, 5'd11, 32'h11);

    // Register 0 write is consumed but not issued
    applyStimulus(0, 0, 1, 5'd0, 32'h55, 0, 5'd0, 32'h0);
    applyStimulus(0, 0, 0, 5'd0, 32'h55, 0, 5'd0, 32'h0);

    // Same destination from both requesters: last write wins
    repeat (2) applyStimulus(0, 0, 1, 5'd12, 32'h1111, 1, 5'd12, 32'h2222);

    // Reset in the cycle after a handshake
    applyStimulus(0, 0, 1, 5'd13, 32'h77, 0, 5'd0, 32'h0);
    applyStimulus(1, 0, 1, 5'd13, 32'h77, 1, 5'd14, 32'h88);
    applyStimulus(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    $display("[TB] directed scenarios done");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
                    1'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom,
                    1'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom);
    end
    $display("[TB] random traffic done");

    // Saturation of wr_cnt0
    applyStimulus(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    for (int i = 0; i < 65540; i++)
      applyStimulus(0, 0, 1, 5'($urandom_range(1, 31)), $urandom, 0, 5'd0, 32'h0);
    checkOutput("sat_cnt0", {48'd0, wr_cnt0}, 64'hFFFF);
    applyStimulus(0, 0, 1, 5'd21, 32'hCAFE, 0, 5'd0, 32'h0);
    checkOutput("sat_write", {63'd0, RegWrite}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
